rx_byte_buffer: RTL and testbench

RX_BYTE_BUFFER -- requirements
Module: rx_byte_buffer

---
 rtl/rx_byte_buffer.sv | 138 +++++++++++++
 tb/tb_rx_byte_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_buffer.sv
// Serial-to-parallel receive buffer: LSB-first shift register feeding a first-word-fall-through FIFO.
// Optional saturating dropped-byte counter enabled by macro RX_BUF_OVERRUN_COUNT_EN.
module rx_byte_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_serial,
    input  logic                     sample_en,
    input  logic                     rx_done,
    input  logic                     frame_error,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_frame_err,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    input  logic                     clear_overrun,
    output logic [7:0]               ovr_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DATA_W + 1;

    logic [DATA_W-1:0] r_shift;
    logic              r_pend_ferr;
    logic              r_rx_done_q;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [EW-1:0]     r_head;
    logic              r_valid;
    logic              r_overrun;

    logic              w_push_att;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic [EW-1:0]     w_entry;
    logic [AW-1:0]     w_rd_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [EW-1:0]     w_head_nxt;

    // Push/pop decisions; a full FIFO still accepts when the head leaves the same cycle
    always_comb begin
        w_push_att = rx_done & ~r_rx_done_q;
        w_pop      = r_valid & m_ready;
        w_full     = (r_count == CW'(DEPTH));
        w_push     = w_push_att & (~w_full | w_pop);
        w_drop     = w_push_att & w_full & ~w_pop;
        w_entry    = {r_pend_ferr | frame_error, r_shift};
        w_rd_nxt   = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Next head: the incoming entry bypasses memory when it lands at the new read slot
    always_comb begin
        w_head_nxt = r_head;
        if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = w_entry;
        end else if (w_cnt_nxt != '0) begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_pend_ferr <= 1'b0;
            r_rx_done_q <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_done_q <= rx_done;
            if (sample_en) begin
                r_shift <= {rx_serial, r_shift[DATA_W-1:1]};
            end
            if (w_push_att) begin
                r_pend_ferr <= 1'b0;
            end else if (frame_error) begin
                r_pend_ferr <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr  <= w_rd_nxt;
            r_count   <= w_cnt_nxt;
            r_head    <= w_head_nxt;
            r_valid   <= (w_cnt_nxt != '0);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage array carries no reset; occupancy tracking alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

`ifdef RX_BUF_OVERRUN_COUNT_EN
    logic [7:0] r_ovr_cnt;

    // A clear coinciding with a drop leaves exactly that one drop counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (clear_overrun) begin
            r_ovr_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign ovr_count = r_ovr_cnt;
`else
    assign ovr_count = 8'd0;
`endif

    assign m_data      = r_head[DATA_W-1:0];
    assign m_frame_err = r_head[DATA_W];
    assign m_valid     = r_valid;
    assign fifo_count  = r_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_rx_byte_buffer.sv
// Scoreboard bench for rx_byte_buffer: expected entries queued on each rx_done edge, compared on pop.
module tb_rx_byte_buffer;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_serial;
    logic          sample_en;
    logic          rx_done;
    logic          frame_error;
    logic [DW-1:0] m_data;
    logic          m_frame_err;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    fifo_count;
    logic          overrun;
    logic          clear_overrun;
    logic [7:0]    ovr_count;

    int          cmp_n = 0;
    int          err_n = 0;
    logic [8:0]  sb_q[$];
    int          mdl_count = 0;
    int          mdl_drops = 0;
    logic        mdl_ovr   = 1'b0;

    always #5 clk = ~clk;

    rx_byte_buffer #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial     (rx_serial),
        .sample_en     (sample_en),
        .rx_done       (rx_done),
        .frame_error   (frame_error),
        .m_data        (m_data),
        .m_frame_err   (m_frame_err),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .ovr_count     (ovr_count)
    );

    function automatic logic [7:0] ovr_exp(input int n);
`ifdef RX_BUF_OVERRUN_COUNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ferr_mode: 0 clean, 1 frame_error one cycle before rx_done, 2 coincident with rx_done edge
    task automatic send_byte(input logic [7:0] d, input int ferr_mode, input int hold,
                             input logic rdy, input logic clr);
        logic [8:0] exp;
        logic       pop;
        for (int i = 0; i < 8; i++) begin
            sample_en = 1'b1;
            rx_serial = d[i];
            tick();
        end
        sample_en = 1'b0;
        rx_serial = 1'b0;
        if (ferr_mode == 1) begin
            frame_error = 1'b1;
            tick();
            frame_error = 1'b0;
        end
        if (mdl_count == 0) begin
            cmp_n++;
            if (m_valid !== 1'b0) begin
                $display("FAIL pre_edge_valid: got %b want 0", m_valid);
                err_n++;
            end
        end
        frame_error   = (ferr_mode == 2);
        rx_done       = 1'b1;
        m_ready       = rdy;
        clear_overrun = clr;
        pop = rdy && (mdl_count > 0);
        if (pop) begin
            exp = sb_q.pop_front();
            cmp_n++;
            if ({m_frame_err, m_data} !== exp) begin
                $display("FAIL edge_pop_head: got %h want %h", {m_frame_err, m_data}, exp);
                err_n++;
            end
        end
        if (clr) begin
            mdl_drops = 0;
            mdl_ovr   = 1'b0;
        end
        if ((mdl_count < int'(DEP)) || pop) begin
            sb_q.push_back({ferr_mode != 0, d});
            if (!pop) mdl_count++;
        end else begin
            mdl_drops++;
            mdl_ovr = 1'b1;
        end
        tick();
        frame_error   = 1'b0;
        m_ready       = 1'b0;
        clear_overrun = 1'b0;
        cmp_n++;
        if ((m_valid !== 1'b1) || (fifo_count !== 3'(mdl_count))) begin
            $display("FAIL post_edge_occupancy: got valid=%b count=%0d want valid=1 count=%0d",
                     m_valid, fifo_count, mdl_count);
            err_n++;
        end
        cmp_n++;
        if ((overrun !== mdl_ovr) || (ovr_count !== ovr_exp(mdl_drops))) begin
            $display("FAIL post_edge_overrun: got ovr=%b cnt=%0d want ovr=%b cnt=%0d",
                     overrun, ovr_count, mdl_ovr, ovr_exp(mdl_drops));
            err_n++;
        end
        for (int i = 1; i < hold; i++) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic drain();
        logic [8:0] exp;
        m_ready = 1'b1;
        for (int k = 0; (k < 40) && (sb_q.size() > 0); k++) begin
            if (m_valid) begin
                exp = sb_q.pop_front();
                mdl_count--;
                cmp_n++;
                if ({m_frame_err, m_data} !== exp) begin
                    $display("FAIL drain_head: got %h want %h", {m_frame_err, m_data}, exp);
                    err_n++;
                end
            end
            tick();
        end
        m_ready = 1'b0;
        cmp_n++;
        if ((sb_q.size() != 0) || (m_valid !== 1'b0) || (fifo_count !== 3'd0)) begin
            $display("FAIL drain_empty: left=%0d valid=%b count=%0d want 0/0/0",
                     sb_q.size(), m_valid, fifo_count);
            err_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_serial = 1'b0; sample_en = 1'b0; rx_done = 1'b0;
        frame_error = 1'b0; m_ready = 1'b0; clear_overrun = 1'b0;
        tick(); tick(); tick();
        cmp_n++;
        if ({m_data, m_frame_err, m_valid, fifo_count, overrun, ovr_count} !== '0) begin
            $display("FAIL reset_outputs: data=%h ferr=%b valid=%b count=%0d ovr=%b cnt=%0d want all 0",
                     m_data, m_frame_err, m_valid, fifo_count, overrun, ovr_count);
            err_n++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        tick(); tick();
        m_ready = 1'b0;
        cmp_n++;
        if ((fifo_count !== 3'd0) || (m_valid !== 1'b0)) begin
            $display("FAIL ready_when_empty: count=%0d valid=%b want 0/0", fifo_count, m_valid);
            err_n++;
        end
        send_byte(8'hA5, 0, 3, 1'b0, 1'b0);
        cmp_n++;
        if ((fifo_count !== 3'd1) || (m_data !== 8'hA5) || (m_frame_err !== 1'b0)) begin
            $display("FAIL long_rx_done: count=%0d data=%h ferr=%b want 1/a5/0",
                     fifo_count, m_data, m_frame_err);
            err_n++;
        end
        drain();
    endtask

    task automatic test_frame_err();
        send_byte(8'h3C, 1, 1, 1'b0, 1'b0);
        send_byte(8'h81, 0, 1, 1'b0, 1'b0);
        send_byte(8'h5A, 2, 2, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_overrun();
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 0, 1, 1'b0, 1'b0);
        cmp_n++;
        if ((fifo_count !== 3'd4) || (overrun !== 1'b1) || (ovr_count !== ovr_exp(1))) begin
            $display("FAIL overrun_state: count=%0d ovr=%b cnt=%0d want 4/1/%0d",
                     fifo_count, overrun, ovr_count, ovr_exp(1));
            err_n++;
        end
        drain();
    endtask

    task automatic test_clear_overrun();
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        mdl_drops = 0;
        mdl_ovr   = 1'b0;
        cmp_n++;
        if ((overrun !== 1'b0) || (ovr_count !== 8'd0)) begin
            $display("FAIL clear_overrun: ovr=%b cnt=%0d want 0/0", overrun, ovr_count);
            err_n++;
        end
        for (int b = 0; b < 6; b++) send_byte(8'h21 + 8'(b), 0, 1, 1'b0, 1'b0);
        send_byte(8'h27, 0, 1, 1'b0, 1'b1);
        cmp_n++;
        if ((overrun !== 1'b1) || (ovr_count !== ovr_exp(1))) begin
            $display("FAIL clear_with_drop: ovr=%b cnt=%0d want 1/%0d", overrun, ovr_count, ovr_exp(1));
            err_n++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        mdl_drops = 0;
        mdl_ovr   = 1'b0;
        for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 0, 1, 1'b0, 1'b0);
        send_byte(8'h77, 0, 1, 1'b1, 1'b0);
        cmp_n++;
        if ((fifo_count !== 3'd4) || (overrun !== 1'b0) || (m_data !== 8'h12)) begin
            $display("FAIL full_pop_push: count=%0d ovr=%b head=%h want 4/0/12",
                     fifo_count, overrun, m_data);
            err_n++;
        end
        drain();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h55, 0, 1, 1'b0, 1'b0);
        send_byte(8'h66, 1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample_en = 1'b1;
            rx_serial = (i != 1);
            tick();
        end
        sample_en = 1'b0;
        rst_n = 1'b0;
        #1;
        cmp_n++;
        if ({m_data, m_frame_err, m_valid, fifo_count, overrun, ovr_count} !== '0) begin
            $display("FAIL midframe_reset: data=%h ferr=%b valid=%b count=%0d ovr=%b cnt=%0d want all 0",
                     m_data, m_frame_err, m_valid, fifo_count, overrun, ovr_count);
            err_n++;
        end
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        mdl_count = 0;
        mdl_drops = 0;
        mdl_ovr   = 1'b0;
        tick();
        send_byte(8'hFF, 0, 1, 1'b0, 1'b0);
        cmp_n++;
        if ((fifo_count !== 3'd1) || (m_data !== 8'hFF)) begin
            $display("FAIL post_reset_entry: count=%0d data=%h want 1/ff", fifo_count, m_data);
            err_n++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_clear_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
